// File: rtl/mem_region_map.sv
// mem_region_map: runtime-programmable, tag-matched region table that classifies NUM_CH address streams.
// Define MEMMAP_FAULT_LOG_EN to add the first-fault capture log (fault_addr/fault_ch/fault_pend, fault_clr).

module mem_region_lane #(
  parameter int ADDR_W      = 32,
  parameter int TAG_W       = 10,
  parameter int NUM_REGIONS = 4,
  parameter int IW          = 2,
  parameter bit FETCH       = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REGIONS-1:0][TAG_W+3:0] tbl,
  input  logic                              req_valid,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic                              req_wr,
  output logic                              rsp_valid,
  output logic                              rsp_cache_en,
  output logic                              rsp_fault,
  output logic [IW-1:0]                     rsp_region
);
  localparam int STAGES = 1;
  localparam int V_B = TAG_W + 3;
  localparam int C_B = TAG_W + 2;
  localparam int X_B = TAG_W + 1;
  localparam int W_B = TAG_W;

  logic [STAGES:0]    vld_pipe;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic [IW-1:0]      idx;
  logic [TAG_W+3:0]   ent;
  logic               cache_d;
  logic               fault_d;

  assign tag         = req_addr[ADDR_W-1 -: TAG_W];
  assign vld_pipe[0] = req_valid;
  assign rsp_valid   = vld_pipe[STAGES];

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    ent = '0;
    for (int r = NUM_REGIONS-1; r >= 0; r--) begin
      if (tbl[r][V_B] && tbl[r][TAG_W-1:0] == tag) begin
        hit = 1'b1;
        idx = IW'(r);
        ent = tbl[r];
      end
    end
  end

  assign cache_d = hit & ent[C_B];
  assign fault_d = !hit || (req_wr && !ent[W_B]) || (FETCH && !ent[X_B]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      rsp_cache_en       <= 1'b0;
      rsp_fault          <= 1'b0;
      rsp_region         <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (req_valid) begin
        rsp_cache_en <= cache_d;
        rsp_fault    <= fault_d;
        rsp_region   <= idx;
      end
    end
  end
endmodule

module mem_region_map #(
  parameter int              ADDR_W      = 32,
  parameter int              TAG_W       = 10,
  parameter int              NUM_CH      = 2,
  parameter int              NUM_REGIONS = 4,
  parameter logic [NUM_CH-1:0] FETCH_MASK = 'b01,
  localparam int             IW          = $clog2(NUM_REGIONS),
  localparam int             CW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [IW-1:0]            cfg_idx,
  input  logic [TAG_W+3:0]         cfg_wdata,
  input  logic                     cfg_lock,
  output logic                     cfg_locked,
  output logic                     cfg_err,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH-1:0]        req_wr,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [NUM_CH-1:0]        rsp_cache_en,
  output logic [NUM_CH-1:0]        rsp_fault,
  output logic [NUM_CH*IW-1:0]     rsp_region
`ifdef MEMMAP_FAULT_LOG_EN
  ,
  input  logic                     fault_clr,
  output logic [ADDR_W-1:0]        fault_addr,
  output logic [CW-1:0]            fault_ch,
  output logic                     fault_pend
`endif
);
  localparam int EW = TAG_W + 4;

  logic [NUM_REGIONS-1:0][EW-1:0] tbl;
  logic                           idx_ok;
  logic                           wr_ok;

  assign idx_ok = int'(cfg_idx) < NUM_REGIONS;
  assign wr_ok  = cfg_we && !cfg_locked && idx_ok;

  // Lookups this cycle see the table as it stood before any same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tbl        <= '0;
      tbl[0]     <= {4'b1111, TAG_W'(0)};
      tbl[1]     <= {4'b1001, TAG_W'(1)};
      tbl[2]     <= {4'b1111, TAG_W'(2)};
      cfg_locked <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      if (wr_ok) tbl[cfg_idx] <= cfg_wdata;
      cfg_err    <= cfg_we && !wr_ok;
      cfg_locked <= cfg_locked | cfg_lock;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    mem_region_lane #(
      .ADDR_W     (ADDR_W),
      .TAG_W      (TAG_W),
      .NUM_REGIONS(NUM_REGIONS),
      .IW         (IW),
      .FETCH      (FETCH_MASK[i])
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .tbl         (tbl),
      .req_valid   (req_valid[i]),
      .req_addr    (req_addr[i*ADDR_W +: ADDR_W]),
      .req_wr      (req_wr[i]),
      .rsp_valid   (rsp_valid[i]),
      .rsp_cache_en(rsp_cache_en[i]),
      .rsp_fault   (rsp_fault[i]),
      .rsp_region  (rsp_region[i*IW +: IW])
    );
  end

`ifdef MEMMAP_FAULT_LOG_EN
  logic [NUM_CH-1:0][ADDR_W-1:0] rsp_addr;
  logic [NUM_CH-1:0]             flt;
  logic                          any_flt;
  logic [CW-1:0]                 flt_ch;
  logic [ADDR_W-1:0]             flt_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_addr <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (req_valid[i]) rsp_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign flt     = rsp_valid & rsp_fault;
  assign any_flt = |flt;

  always_comb begin
    flt_ch   = '0;
    flt_addr = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (flt[i]) begin
        flt_ch   = CW'(i);
        flt_addr = rsp_addr[i];
      end
    end
  end

  // A fresh fault beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_pend <= 1'b0;
      fault_addr <= '0;
      fault_ch   <= '0;
    end else if (any_flt && (!fault_pend || fault_clr)) begin
      fault_pend <= 1'b1;
      fault_addr <= flt_addr;
      fault_ch   <= flt_ch;
    end else if (fault_clr) begin
      fault_pend <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_mem_region_map.sv
// Scoreboard bench for mem_region_map: stimulus pushes predicted responses, a negedge monitor pops and compares.
module tb_mem_region_map;
  localparam int AW  = 32;
  localparam int TW  = 10;
  localparam int NCH = 2;
  localparam int NR  = 5;
  localparam int IW  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we, cfg_lock, cfg_locked, cfg_err;
  logic [IW-1:0]     cfg_idx;
  logic [TW+3:0]     cfg_wdata;
  logic [NCH-1:0]    req_valid, req_wr, rsp_valid, rsp_cache_en, rsp_fault;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*IW-1:0] rsp_region;
  logic              fault_clr;
`ifdef MEMMAP_FAULT_LOG_EN
  logic [AW-1:0]     fault_addr;
  logic              fault_ch;
  logic              fault_pend;
`endif

  mem_region_map #(.ADDR_W(AW), .TAG_W(TW), .NUM_CH(NCH), .NUM_REGIONS(NR), .FETCH_MASK(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
    .cfg_lock(cfg_lock), .cfg_locked(cfg_locked), .cfg_err(cfg_err),
    .req_valid(req_valid), .req_addr(req_addr), .req_wr(req_wr),
    .rsp_valid(rsp_valid), .rsp_cache_en(rsp_cache_en), .rsp_fault(rsp_fault), .rsp_region(rsp_region)
`ifdef MEMMAP_FAULT_LOG_EN
    , .fault_clr(fault_clr), .fault_addr(fault_addr), .fault_ch(fault_ch), .fault_pend(fault_pend)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Reference table: one record per region, looked up first-match from index 0.
  logic          m_v [NR];
  logic          m_c [NR];
  logic          m_x [NR];
  logic          m_w [NR];
  logic [TW-1:0] m_tag [NR];
  logic          m_locked = 0;
  logic          m_err = 0;

  typedef struct {
    int            due;
    logic          ce;
    logic          f;
    logic [IW-1:0] r;
    logic [AW-1:0] a;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  logic          last_ce [NCH];
  logic          last_f  [NCH];
  logic [IW-1:0] last_r  [NCH];
  logic          got_f   [NCH];
  logic [AW-1:0] got_a   [NCH];
  logic          fl_pend = 0;
  logic          fl_ch = 0;
  logic [AW-1:0] fl_addr = '0;

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_v[r] = 0; m_c[r] = 0; m_x[r] = 0; m_w[r] = 0; m_tag[r] = '0;
    end
    for (int r = 0; r < 3; r++) begin
      m_v[r] = 1; m_tag[r] = TW'(r);
      m_c[r] = (r != 1); m_x[r] = (r != 1); m_w[r] = 1;
    end
    for (int c = 0; c < NCH; c++) begin
      last_ce[c] = 0; last_f[c] = 0; last_r[c] = '0;
    end
    m_locked = 0;
    m_err = 0;
  endtask

  function automatic exp_t predict(int ch, logic [AW-1:0] a, logic wr);
    exp_t e;
    e.due = cyc + 1; e.a = a; e.ce = 0; e.f = 1; e.r = '0;
    for (int r = 0; r < NR; r++) begin
      if (m_v[r] && m_tag[r] == a[AW-1 -: TW]) begin
        e.ce = m_c[r];
        e.f  = (wr && !m_w[r]) || (ch == 0 && !m_x[r]);
        e.r  = IW'(r);
        return e;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic idle();
    cfg_we = 0; cfg_lock = 0; cfg_idx = '0; cfg_wdata = '0;
    req_valid = '0; req_wr = '0; req_addr = '0; fault_clr = 0;
  endtask

  task automatic req(input int ch, input logic [AW-1:0] a, input logic wr);
    req_valid[ch] = 1'b1;
    req_wr[ch] = wr;
    req_addr[ch*AW +: AW] = a;
  endtask

  task automatic cfg(input int idx, input logic [3:0] flags, input logic [TW-1:0] tag);
    cfg_we = 1'b1;
    cfg_idx = IW'(idx);
    cfg_wdata = {flags, tag};
  endtask

  // Predict from the pre-edge table, clock once, then apply the config/lock/reset effects.
  task automatic tick();
    exp_t e;
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        if (req_valid[c]) begin
          e = predict(c, req_addr[c*AW +: AW], req_wr[c]);
          if (c == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      q0.delete();
      q1.delete();
    end else begin
      m_err = cfg_we && (m_locked || int'(cfg_idx) >= NR);
      if (cfg_we && !m_err) begin
        m_v[cfg_idx] = cfg_wdata[TW+3]; m_c[cfg_idx] = cfg_wdata[TW+2];
        m_x[cfg_idx] = cfg_wdata[TW+1]; m_w[cfg_idx] = cfg_wdata[TW];
        m_tag[cfg_idx] = cfg_wdata[TW-1:0];
      end
      m_locked = m_locked | cfg_lock;
    end
    #1;
  endtask

  task automatic chk_ch(input int ch);
    exp_t e;
    bit   have;
    got_f[ch] = 0;
    got_a[ch] = '0;
    have = (ch == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (have) e = (ch == 0) ? q0[0] : q1[0];
    if (rsp_valid[ch]) begin
      if (!have) begin
        chk($sformatf("unexpected_rsp_valid%0d", ch), 64'(rsp_valid[ch]), 64'd0);
      end else begin
        if (ch == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk($sformatf("latency%0d", ch), 64'(cyc), 64'(e.due));
        chk($sformatf("cache_en%0d", ch), 64'(rsp_cache_en[ch]), 64'(e.ce));
        chk($sformatf("fault%0d", ch), 64'(rsp_fault[ch]), 64'(e.f));
        chk($sformatf("region%0d", ch), 64'(rsp_region[ch*IW +: IW]), 64'(e.r));
        last_ce[ch] = e.ce; last_f[ch] = e.f; last_r[ch] = e.r;
        got_f[ch] = e.f; got_a[ch] = e.a;
      end
    end else begin
      chk($sformatf("hold_cache_en%0d", ch), 64'(rsp_cache_en[ch]), 64'(last_ce[ch]));
      chk($sformatf("hold_fault%0d", ch), 64'(rsp_fault[ch]), 64'(last_f[ch]));
      chk($sformatf("hold_region%0d", ch), 64'(rsp_region[ch*IW +: IW]), 64'(last_r[ch]));
      if (have && e.due <= cyc) begin
        chk($sformatf("missing_rsp_valid%0d", ch), 64'(rsp_valid[ch]), 64'd1);
        if (ch == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk_ch(0);
      chk_ch(1);
      chk("cfg_err", 64'(cfg_err), 64'(m_err));
      chk("cfg_locked", 64'(cfg_locked), 64'(m_locked));
`ifdef MEMMAP_FAULT_LOG_EN
      chk("fault_pend", 64'(fault_pend), 64'(fl_pend));
      chk("fault_ch", 64'(fault_ch), 64'(fl_ch));
      chk("fault_addr", 64'(fault_addr), 64'(fl_addr));
`endif
      if (!rst_n) begin
        fl_pend = 0; fl_ch = 0; fl_addr = '0;
      end else if ((got_f[0] || got_f[1]) && (!fl_pend || fault_clr)) begin
        fl_pend = 1;
        fl_ch   = got_f[0] ? 1'b0 : 1'b1;
        fl_addr = got_f[0] ? got_a[0] : got_a[1];
      end else if (fault_clr) begin
        fl_pend = 0;
      end
    end
  end

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] a;
    a = $urandom;
    case ($urandom_range(0, 5))
      0: a[AW-1 -: TW] = 10'h000;
      1: a[AW-1 -: TW] = 10'h001;
      2: a[AW-1 -: TW] = 10'h002;
      3: a[AW-1 -: TW] = 10'h003;
      4: a[AW-1 -: TW] = 10'h3FF;
      default: ;
    endcase
    return a;
  endfunction

  initial begin
    idle();
    model_reset();
    rst_n = 0; tick(); tick();
    started = 1;
    rst_n = 1;

    // Default-table lookups.
    req(0, 32'h0000_1000, 0); tick(); idle();
    req(1, 32'h0040_0000, 0); tick(); idle();
    req(1, 32'h0080_0004, 0); tick(); idle();
    // Miss and permissions.
    req(1, 32'h0100_0000, 0); tick(); idle();
    req(1, 32'h0040_0000, 1); tick(); idle();
    req(0, 32'h0040_0000, 0); tick(); idle();
    // Reprogram entry 3; the same-cycle lookup still sees the old table.
    cfg(3, 4'b1100, 10'h3FF); req(1, 32'hFFC0_0000, 0); tick(); idle();
    req(1, 32'hFFC0_0000, 0); tick(); idle();
    req(1, 32'hFFC0_0000, 1); tick(); idle();
    // Lowest matching index wins.
    cfg(3, 4'b1011, 10'h000); tick(); idle();
    req(1, 32'h0000_0010, 0); tick(); idle();
    // Out-of-range index.
    cfg(NR, 4'b1111, 10'h055); tick(); idle();
    cfg(7, 4'b1111, 10'h055); tick(); idle();
    tick();
    // Faults on both channels, then a clear coinciding with a new fault.
    req(0, 32'h0200_0000, 0); req(1, 32'h0300_0004, 0); tick(); idle();
    tick();
    req(1, 32'h0500_0008, 0); tick(); idle();
    fault_clr = 1; tick(); idle();
    fault_clr = 1; tick(); idle();
    tick();
    // Lock with a same-cycle write, then a rejected write.
    cfg(1, 4'b1111, 10'h001); cfg_lock = 1; tick(); idle();
    req(0, 32'h0040_0000, 0); tick(); idle();
    cfg(2, 4'b0000, 10'h002); tick(); idle();
    req(1, 32'h0080_0000, 0); tick(); idle();
    // Reset mid-operation restores defaults and drops in-flight requests.
    req(0, 32'h0000_0000, 0); req(1, 32'h0040_0000, 0); rst_n = 0; tick();
    rst_n = 1; idle(); tick();
    req(0, 32'h0040_0000, 0); req(1, 32'h0040_0000, 1); tick(); idle();

    for (int n = 0; n < 600; n++) begin
      idle();
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) != 0) req(c, pick_addr(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) begin
        cfg($urandom_range(0, 7), 4'($urandom), 10'($urandom_range(0, 4)));
        if (cfg_wdata[TW-1:0] == 10'd4) cfg_wdata[TW-1:0] = 10'h3FF;
      end
      cfg_lock  = ($urandom_range(0, 149) == 0);
      fault_clr = ($urandom_range(0, 3) == 0);
      rst_n     = ($urandom_range(0, 79) != 0);
      tick();
    end

    rst_n = 1; idle(); tick(); tick(); tick();
    chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_region_map.md
Name: mem_region_map

Overview:
- Parametrised, programmable successor to the fixed-tag cacheability decoder.
- Classifies NUM_CH address streams against a runtime-writable table of NUM_REGIONS tag-matched regions.
- Returns registered attributes (cache enable, fault) one cycle after each request.
- Sits between the core's fetch/load-store address outputs and the I/D cache front-ends; channel 0 is the fetch stream.

Parameters:
- ADDR_W, 32, address width.
- TAG_W, 10, tag width; tag = addr[ADDR_W-1 -: TAG_W].
- NUM_CH, 2, number of lookup channels (ch0 = imem, ch1 = dmem).
- NUM_REGIONS, 4, table entries (>=3).
- FETCH_MASK, 'b01, per-channel bit; 1 = channel is instruction fetch (exec check applies).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  clog2(NUM_REGIONS)  entry index.
- cfg_wdata  in  TAG_W+4  {valid, cacheable, executable, writable, tag}, MSB first.
- cfg_lock  in  1  lock request (sticky).
- cfg_locked  out  1  lock state.
- cfg_err  out  1  one-cycle pulse: write rejected.
- req_valid  in  NUM_CH  per-channel request.
- req_addr  in  NUM_CH*ADDR_W  packed addresses; ch i at [i*ADDR_W +: ADDR_W].
- req_wr  in  NUM_CH  1 = store access.
- rsp_valid  out  NUM_CH  result valid.
- rsp_cache_en  out  NUM_CH  cacheable.
- rsp_fault  out  NUM_CH  access violation.
- rsp_region  out  NUM_CH*clog2(NUM_REGIONS)  matching entry index (0 on miss).

Behaviour:
- Reset (rst_n=0 at posedge):
  - Entry0 = {1,1,1,1,tag 0}; entry1 = {1,0,0,1,tag 1}; entry2 = {1,1,1,1,tag 2}; all other entries invalid, all fields 0.
  - cfg_locked=0, cfg_err=0; all rsp_* = 0.
  - Reset mid-operation drops any in-flight result; no rsp_valid the following cycle.
- Lookup: registered, latency 1.
  - req_valid[i] at edge N gives rsp_valid[i]=1 after edge N+1, with the result for that address; otherwise rsp_valid[i]=0.
  - rsp_* fields hold their previous value when rsp_valid=0.
  - Channels are fully independent; all may issue every cycle; no backpressure.
- Match: entry valid && entry.tag == address tag. Multiple matches: lowest index wins.
- Hit results:
  - rsp_cache_en = cacheable.
  - rsp_fault = (req_wr && !writable) || (FETCH_MASK[i] && !executable).
  - rsp_region = matching index.
- Miss results: rsp_cache_en=0, rsp_fault=1, rsp_region=0. Closes the previous gap where an unmatched dmem tag held a stale value.
- Config write: cfg_we=1 && !cfg_locked updates entry cfg_idx at the edge; cfg_err stays 0.
  - cfg_idx >= NUM_REGIONS: write ignored, cfg_err=1 next cycle.
  - cfg_we=1 while cfg_locked: write ignored, cfg_err=1 next cycle.
- Ordering: a lookup and a config write in the same cycle use the old table. The new entry applies to requests from the next cycle on.
- Lock: cfg_lock=1 sets cfg_locked at the edge; it clears only on reset. A write in the same cycle as cfg_lock (lock not yet set) is accepted.

Optional Feature:
- Macro MEMMAP_FAULT_LOG_EN.
- Defined: adds outputs fault_addr (ADDR_W), fault_ch (clog2(NUM_CH), min 1), fault_pend (1), and input fault_clr (1).
  - The first rsp_fault=1 with rsp_valid=1 while fault_pend=0 captures its address and channel and sets fault_pend.
  - Later faults do not overwrite the capture.
  - On simultaneous faults, the lowest channel is captured.
  - fault_clr clears fault_pend next cycle; a fault arriving in the same cycle as fault_clr is captured (set wins).
  - All three outputs reset to 0.
- Undefined: these ports and their logic are absent; the rest of the behaviour is identical.

Test Plan:
- Post-reset lookups, all req_wr=0:
  - ch0=0x0000_1000 -> rsp_cache_en=1, fault=0, region=0.
  - ch1=0x0040_0000 -> cache_en=0, fault=0, region=1.
  - ch1=0x0080_0004 -> cache_en=1, region=2.
  - Each rsp_valid appears exactly 1 cycle after its request.
- Miss and permissions:
  - ch1=0x0100_0000 -> cache_en=0, fault=1.
  - ch1 store to 0x0040_0000 -> fault=0.
  - ch0 fetch from 0x0040_0000 -> fault=1 (entry1 not executable).
- Reprogram: write idx3 = {1,1,0,0,tag 0x3FF}.
  - Same-cycle ch1 req 0xFFC0_0000 -> fault=1 (old table).
  - Next-cycle load -> cache_en=1, fault=0, region=3.
  - Store to same address -> fault=1.
- Priority: write idx3 with tag 0, cacheable=0; ch1 load 0x0000_0010 -> region=0, cache_en=1.
- Lock:
  - cfg_lock=1 together with a write to idx1 -> write accepted, cfg_locked=1.
  - Subsequent write -> ignored, cfg_err pulses 1 cycle.
  - Write with cfg_idx=NUM_REGIONS -> cfg_err.
  - Reset -> cfg_locked=0, table restored to defaults.
- Mid-operation reset: rst_n=0 in the same cycle as req_valid=2'b11 -> rsp_valid=0 next cycle.
  - With MEMMAP_FAULT_LOG_EN: faults on ch0 and ch1 in the same cycle -> fault_ch=0; fault_clr plus a new fault in the same cycle -> fault_pend stays 1 and the new address is captured.
